// File: rtl/uart_packet_parser_if.sv
// Byte-stream input and operand-word output bundle for uart_packet_parser.
// The parser connects through the slave modport; the byte source and word sink use master.
interface uart_packet_parser_if #(
  parameter int DATA_WIDTH_P = 8,
  parameter int WORD_BYTES_P = 4
);
  logic [DATA_WIDTH_P-1:0]              s_axis_tdata;
  logic                                 s_axis_tvalid;
  logic                                 s_axis_tready;
  logic [DATA_WIDTH_P*WORD_BYTES_P-1:0] m_tdata;
  logic [DATA_WIDTH_P-1:0]              m_op;
  logic                                 m_tvalid;
  logic                                 m_tready;
  logic                                 m_tlast;
  logic                                 err_o;
  logic [1:0]                           err_code_o;
  logic                                 busy_o;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_tready,
    output s_axis_tready, m_tdata, m_op, m_tvalid, m_tlast, err_o, err_code_o, busy_o
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_tready,
    input  s_axis_tready, m_tdata, m_op, m_tvalid, m_tlast, err_o, err_code_o, busy_o
  );
endinterface

// File: rtl/uart_packet_parser.sv
// Parses opcode/length-framed packets from a UART byte stream into little-endian operand words.
// Malformed headers raise a one-cycle error pulse and the rest of the packet is drained.
module uart_packet_parser #(
  parameter int DATA_WIDTH_P = 8,
  parameter int WORD_BYTES_P = 4
) (
  input  logic               clk,
  input  logic               rst,
  uart_packet_parser_if.slave bus
);

  localparam int WORD_W = DATA_WIDTH_P * WORD_BYTES_P;
  localparam int IDX_W  = (WORD_BYTES_P > 1) ? $clog2(WORD_BYTES_P) : 1;

  typedef enum logic [2:0] {
    IDLE, RSVD, LEN_LO, LEN_HI, PAYLOAD, WORD_OUT, DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH_P-1:0] op_q, op_d;
  logic [DATA_WIDTH_P-1:0] len_lo_q, len_lo_d;
  logic [15:0]             rem_q, rem_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
  logic                    tlast_q, tlast_d;
  logic                    err_q, err_d;
  logic [1:0]              err_code_q, err_code_d;

  logic        accept;
  logic [15:0] len_full;
  logic        bad_op;
  logic        bad_len;

  assign bus.s_axis_tready = (state_q != WORD_OUT);
  assign accept            = bus.s_axis_tvalid & bus.s_axis_tready;
  assign len_full          = {bus.s_axis_tdata, len_lo_q};
  assign bad_op            = !(op_q inside {8'hA0, 8'hA1, 8'hA2});
  assign bad_len           = (len_full < 16'd8) || (len_full[1:0] != 2'b00);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_lo_d   = len_lo_q;
    rem_d      = rem_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    tlast_d    = tlast_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      IDLE: if (accept) begin
        op_d    = bus.s_axis_tdata;
        state_d = RSVD;
      end
      RSVD: if (accept) state_d = LEN_LO;
      LEN_LO: if (accept) begin
        len_lo_d = bus.s_axis_tdata;
        state_d  = LEN_HI;
      end
      LEN_HI: if (accept) begin
        // A LEN below the header size clamps to zero rather than wrapping.
        rem_d      = (len_full < 16'd4) ? 16'd0 : len_full - 16'd4;
        byte_idx_d = '0;
        if (bad_op || bad_len) begin
          err_d      = 1'b1;
          err_code_d = bad_op ? 2'd1 : 2'd2;
          state_d    = (len_full > 16'd4) ? DRAIN : IDLE;
        end else begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (accept) begin
        for (int i = 0; i < WORD_BYTES_P; i++) begin
          if (byte_idx_q == IDX_W'(i)) word_d[i*DATA_WIDTH_P +: DATA_WIDTH_P] = bus.s_axis_tdata;
        end
        rem_d      = rem_q - 16'd1;
        byte_idx_d = byte_idx_q + 1'b1;
        if (byte_idx_q == IDX_W'(WORD_BYTES_P - 1)) begin
          tlast_d = (rem_q == 16'd1);
          state_d = WORD_OUT;
        end
      end
      WORD_OUT: if (bus.m_tready) state_d = tlast_q ? IDLE : PAYLOAD;
      DRAIN: if (accept) begin
        rem_d = rem_q - 16'd1;
        if (rem_q == 16'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      len_lo_q   <= '0;
      rem_q      <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      tlast_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_lo_q   <= len_lo_d;
      rem_q      <= rem_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      tlast_q    <= tlast_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.m_tdata    = word_q;
  assign bus.m_op       = op_q;
  assign bus.m_tvalid   = (state_q == WORD_OUT);
  assign bus.m_tlast    = tlast_q;
  assign bus.err_o      = err_q;
  assign bus.err_code_o = err_code_q;
  assign bus.busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_packet_parser.sv
// Directed self-checking bench for uart_packet_parser: valid packets, backpressure,
// header errors with drain, short length and mid-packet reset.
module tb_uart_packet_parser;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] got_word[$];
  logic        got_last[$];
  logic [7:0]  got_op[$];
  int          err_pulses;

  uart_packet_parser_if bus ();

  uart_packet_parser #(.DATA_WIDTH_P(8), .WORD_BYTES_P(4)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after a rising edge, so the falling edge sees what the next edge will sample.
  always @(negedge clk) begin
    if (bus.m_tvalid && bus.m_tready) begin
      got_word.push_back(bus.m_tdata);
      got_last.push_back(bus.m_tlast);
      got_op.push_back(bus.m_op);
    end
    if (bus.err_o) err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    bus.s_axis_tdata  = b;
    bus.s_axis_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("byte_accept_timeout", 32'(acc), 32'd1);
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_capture();
    got_word.delete();
    got_last.delete();
    got_op.delete();
    err_pulses = 0;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    err_pulses        = 0;
    rst_n             = 1'b0;
    bus.s_axis_tdata  = 8'h00;
    bus.s_axis_tvalid = 1'b0;
    bus.m_tready      = 1'b1;

    // Reset values while rst is held low
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", 32'(bus.s_axis_tready), 32'd1);
    check("rst_tvalid", 32'(bus.m_tvalid), 32'd0);
    check("rst_tlast", 32'(bus.m_tlast), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_tdata", bus.m_tdata, 32'd0);
    check("rst_op", 32'(bus.m_op), 32'd0);
    check("rst_err_code", 32'(bus.err_code_o), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Valid two-word packet with the sink always ready
    clear_capture();
    send_bytes('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'h04, 8'h03, 8'h02, 8'h01});
    idle_cycles(3);
    check("valid_count", 32'(got_word.size()), 32'd2);
    if (got_word.size() == 2) begin
      check("valid_w0", got_word[0], 32'h12345678);
      check("valid_l0", 32'(got_last[0]), 32'd0);
      check("valid_w1", got_word[1], 32'h01020304);
      check("valid_l1", 32'(got_last[1]), 32'd1);
      check("valid_op", 32'(got_op[1]), 32'hA0);
    end
    check("valid_no_err", 32'(err_pulses), 32'd0);
    check("valid_idle", 32'(bus.busy_o), 32'd0);

    // Backpressure on the first word
    clear_capture();
    bus.m_tready = 1'b0;
    send_bytes('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_tready", 32'(bus.s_axis_tready), 32'd0);
      check("bp_tvalid", 32'(bus.m_tvalid), 32'd1);
      check("bp_tdata", bus.m_tdata, 32'h12345678);
    end
    check("bp_tlast", 32'(bus.m_tlast), 32'd0);
    @(posedge clk);
    #1;
    bus.m_tready = 1'b1;
    send_bytes('{8'h04, 8'h03, 8'h02, 8'h01});
    idle_cycles(3);
    check("bp_count", 32'(got_word.size()), 32'd2);
    if (got_word.size() == 2) begin
      check("bp_w0", got_word[0], 32'h12345678);
      check("bp_w1", got_word[1], 32'h01020304);
      check("bp_l1", 32'(got_last[1]), 32'd1);
    end

    // Bad opcode: error code 1, payload drained, following packet parsed normally
    clear_capture();
    send_bytes('{8'h55, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88});
    idle_cycles(2);
    check("badop_no_words", 32'(got_word.size()), 32'd0);
    check("badop_code", 32'(bus.err_code_o), 32'd1);
    check("badop_idle", 32'(bus.busy_o), 32'd0);
    send_bytes('{8'hA1, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    idle_cycles(3);
    check("badop_pulses", 32'(err_pulses), 32'd1);
    check("badop_next_count", 32'(got_word.size()), 32'd1);
    if (got_word.size() == 1) begin
      check("badop_next_word", got_word[0], 32'hDEADBEEF);
      check("badop_next_last", 32'(got_last[0]), 32'd1);
      check("badop_next_op", 32'(got_op[0]), 32'hA1);
    end

    // Bad length 6: error code 2, both payload bytes drained
    clear_capture();
    send_bytes('{8'hA2, 8'h00, 8'h06, 8'h00});
    idle_cycles(1);
    check("badlen_code", 32'(bus.err_code_o), 32'd2);
    check("badlen_drain_busy", 32'(bus.busy_o), 32'd1);
    send_byte(8'hAA);
    check("badlen_mid_busy", 32'(bus.busy_o), 32'd1);
    send_byte(8'hBB);
    check("badlen_done_busy", 32'(bus.busy_o), 32'd0);
    check("badlen_pulses", 32'(err_pulses), 32'd1);

    // Short length 3: error, straight back to IDLE with nothing drained
    clear_capture();
    send_bytes('{8'hA0, 8'h00, 8'h03, 8'h00});
    check("short_busy", 32'(bus.busy_o), 32'd0);
    idle_cycles(1);
    check("short_code", 32'(bus.err_code_o), 32'd2);
    send_bytes('{8'hA1, 8'h00, 8'h08, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01});
    idle_cycles(3);
    check("short_pulses", 32'(err_pulses), 32'd1);
    check("short_next_count", 32'(got_word.size()), 32'd1);
    if (got_word.size() == 1) check("short_next_word", got_word[0], 32'h01020304);

    // Reset mid-packet: partial packet dropped, next packet starts at its opcode
    clear_capture();
    send_bytes('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22});
    rst_n = 1'b0;
    #2;
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    check("midrst_tready", 32'(bus.s_axis_tready), 32'd1);
    check("midrst_tdata", bus.m_tdata, 32'd0);
    check("midrst_op", 32'(bus.m_op), 32'd0);
    check("midrst_code", 32'(bus.err_code_o), 32'd0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    send_bytes('{8'hA2, 8'h00, 8'h08, 8'h00, 8'h88, 8'h77, 8'h66, 8'h55});
    idle_cycles(3);
    check("midrst_count", 32'(got_word.size()), 32'd1);
    if (got_word.size() == 1) begin
      check("midrst_word", got_word[0], 32'h55667788);
      check("midrst_last", 32'(got_last[0]), 32'd1);
      check("midrst_op_out", 32'(got_op[0]), 32'hA2);
    end
    check("midrst_no_err", 32'(err_pulses), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_packet_parser.md
UART_PACKET_PARSER -- requirements
Module: uart_packet_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH_P, default 8, the UART byte width; only 8 is supported.
REQ-002 SHALL have parameter WORD_BYTES_P, default 4, the number of bytes per operand word.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset; asynchronous and active-low, so state is reset while rst==0.
REQ-005 SHALL have port s_axis_tdata, input, 8 bits: the received byte from the UART m_axis output.
REQ-006 SHALL have port s_axis_tvalid, input, 1 bit: the received byte is valid.
REQ-007 SHALL have port s_axis_tready, output, 1 bit: the parser accepts the byte.
REQ-008 SHALL have port m_tdata, output, 32 bits: the assembled operand word, little-endian.
REQ-009 SHALL have port m_op, output, 8 bits: the opcode of the current packet, stable while m_tvalid==1.
REQ-010 SHALL have ports m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1): the operand word handshake, where m_tlast marks the final word.
REQ-011 SHALL have port err_o, output, 1 bit: a one-cycle pulse on a malformed header.
REQ-012 SHALL have port err_code_o, output, 2 bits: 1 for a bad opcode, 2 for a bad length; it is held until the next error.
REQ-013 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL treat a byte as accepted only on a cycle where s_axis_tvalid and s_axis_tready are both 1.
REQ-015 SHALL use this packet format:
- byte0 = opcode;
- byte1 = reserved (ignored);
- byte2 = LEN[7:0];
- byte3 = LEN[15:8];
- then LEN-4 payload bytes, where LEN is the total packet byte count.
REQ-016 SHALL recognise only the valid opcodes 0xA0 (add), 0xA1 (mul) and 0xA2 (div).
REQ-017 SHALL use the FSM states IDLE, RSVD, LEN_LO, LEN_HI, PAYLOAD, WORD_OUT and DRAIN.
REQ-018 SHALL, in IDLE, RSVD and LEN_LO, advance one state per accepted byte; in IDLE it latches the opcode into m_op.
REQ-019 SHALL, on the LEN_HI accept, load the 16-bit remaining counter with LEN-4, using wrap-free arithmetic (LEN<4 counts as a length error).
REQ-020 SHALL, on the LEN_HI accept, take these transitions:
- bad opcode or LEN<8 or LEN[1:0]!=0 -> pulse err_o the next cycle and set err_code_o (bad opcode takes priority);
- then, if LEN>4 -> DRAIN; otherwise -> IDLE;
- valid header -> PAYLOAD.
REQ-021 SHALL, in PAYLOAD, shift each accepted byte into byte lane [byte_idx] and decrement the remaining counter.
REQ-022 SHALL, on accepting the 4th byte of a word, enter WORD_OUT with m_tvalid=1 on the next cycle (1-cycle latency).
REQ-023 SHALL set m_tlast=1 when the remaining counter reaches 0 with that word.
REQ-024 SHALL hold s_axis_tready=0 in WORD_OUT, and hold m_tdata, m_tlast and m_op stable until m_tready==1.
REQ-025 SHALL, on the WORD_OUT handshake, go to IDLE if m_tlast==1 and to PAYLOAD otherwise; m_tvalid falls the following cycle.
REQ-026 SHALL, in DRAIN, discard accepted bytes and decrement the counter, returning to IDLE on the accept that makes the counter 0.
REQ-027 SHALL drive s_axis_tready=1 in every state except WORD_OUT.
REQ-028 SHALL leave s_axis_tvalid gaps (no accept) with no effect on state or counters.
REQ-029 SHALL allow a new packet to start on the cycle after returning to IDLE, with no idle gap required.
REQ-030 SHALL, when m_tready==1 in the same cycle as m_tvalid rises, complete the handshake that cycle.

Reset
REQ-031 SHALL, while rst==0, force immediately:
- state to IDLE;
- s_axis_tready to 1;
- m_tvalid, m_tlast, err_o and busy_o to 0;
- m_tdata, m_op and err_code_o to 0;
- the counters to 0.
REQ-032 SHALL discard any partial packet or pending word when rst asserts mid-operation; after release the first accepted byte is an opcode.

Verification
REQ-033 SHALL cover a valid packet: send A0 00 0C 00 78 56 34 12 04 03 02 01 with m_tready=1 -> words 0x12345678 (tlast=0) then 0x01020304 (tlast=1), m_op=0xA0, err_o never pulses.
REQ-034 SHALL cover backpressure: same packet with m_tready=0 for 20 cycles after the first word -> s_axis_tready=0 and m_tdata stable throughout; the second word is delivered after release.
REQ-035 SHALL cover a bad opcode: send 55 00 0C 00 + 8 bytes, then A1 00 08 00 EF BE AD DE -> err_o pulses once with err_code_o=1; the 8 bytes produce no output; the next packet yields 0xDEADBEEF, tlast=1, m_op=0xA1.
REQ-036 SHALL cover a bad length: send A2 00 06 00 AA BB -> err_code_o=2; both payload bytes are drained; busy_o=0 after the last byte.
REQ-037 SHALL cover a short length: send A0 00 03 00 -> err_code_o=2; the FSM returns directly to IDLE with no drain.
REQ-038 SHALL cover mid-reset: assert rst=0 after 6 bytes of a valid packet, release, then send a full valid packet -> the only word output comes from the second packet.
